// File: rtl/alu_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_execute_stage
// Description : Single-entry registered ALU execute stage with valid/ready
//               handshake on both sides, flush, and an architectural NZCV
//               flags register updated by flag-setting add/subtract ops.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               in_valid/ready  - upstream handshake
//               alu_cntrl       - opcode (000 pass B, 010 add, 011 sub,
//                                 100 and, 101 or, 110 xor, others illegal)
//               set_flags       - op commits NZCV when accepted
//               op_a, op_b      - operands
//               flush           - drop held result and any offered op
//               out_valid/ready - downstream handshake
//               result, out_zero, out_illegal - registered result
//               flags           - architectural {N,Z,C,V}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_execute_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_cntrl,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [3:0]       flags
);

  localparam logic [2:0] c_OP_PASS = 3'b000;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_SUB  = 3'b011;
  localparam logic [2:0] c_OP_AND  = 3'b100;
  localparam logic [2:0] c_OP_OR   = 3'b101;
  localparam logic [2:0] c_OP_XOR  = 3'b110;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic [3:0]       r_flags;

  logic [WIDTH:0]   w_sum_add;
  logic [WIDTH:0]   w_sum_sub;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal;
  logic             w_carry;
  logic             w_ovf;
  logic             w_accept;

  // Subtraction as a + ~b + 1: the carry-out is exactly "no borrow".
  assign w_sum_add = {1'b0, op_a} + {1'b0, op_b};
  assign w_sum_sub = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    case (alu_cntrl)
      c_OP_PASS: w_result = op_b;
      c_OP_ADD: begin
        w_result = w_sum_add[WIDTH-1:0];
        w_carry  = w_sum_add[WIDTH];
        w_ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                   (w_sum_add[WIDTH-1] != op_a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_result = w_sum_sub[WIDTH-1:0];
        w_carry  = w_sum_sub[WIDTH];
        w_ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                   (w_sum_sub[WIDTH-1] != op_a[WIDTH-1]);
      end
      c_OP_AND: w_result = op_a & op_b;
      c_OP_OR:  w_result = op_a | op_b;
      c_OP_XOR: w_result = op_a ^ op_b;
      default:  w_illegal = 1'b1;
    endcase
  end

  // Single-entry buffer: can take a new op whenever the held one leaves.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_flags   <= 4'b0000;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_accept) begin
        r_result  <= w_result;
        r_zero    <= (w_result == '0);
        r_illegal <= w_illegal;
        if (set_flags && !w_illegal) begin
          r_flags <= {w_result[WIDTH-1], (w_result == '0), w_carry, w_ovf};
        end
      end
    end
  end

  assign out_valid   = r_valid;
  assign result      = r_result;
  assign out_zero    = r_zero;
  assign out_illegal = r_illegal;
  assign flags       = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_execute_stage
// Description : Directed self-checking bench for alu_execute_stage with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_cntrl;
  logic        set_flags;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        out_zero;
  logic        out_illegal;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_execute_stage #(.WIDTH(64)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_cntrl   (alu_cntrl),
    .set_flags   (set_flags),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] c, input logic sf, input logic [63:0] a, input logic [63:0] b);
    in_valid  = 1'b1;
    alu_cntrl = c;
    set_flags = sf;
    op_a      = a;
    op_b      = b;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_cntrl = 3'b000; set_flags = 1'b0;
    op_a = '0; op_b = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    check("rst_valid",   64'(out_valid),   64'd0);
    check("rst_result",  result,           64'd0);
    check("rst_zero",    64'(out_zero),    64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    check("rst_flags",   64'(flags),       64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // ADDS signed overflow
    offer(3'b010, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); step(); in_valid = 1'b0;
    check("adds_ovf_res",   result,        64'h8000_0000_0000_0000);
    check("adds_ovf_flags", 64'(flags),    64'h9);
    check("adds_ovf_zero",  64'(out_zero), 64'd0);
    check("adds_ovf_valid", 64'(out_valid), 64'd1);

    // ADDS carry-out to zero
    offer(3'b010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); step();
    check("adds_c_res",   result,     64'd0);
    check("adds_c_flags", 64'(flags), 64'h6);

    // SUBS equal, then 3-5
    offer(3'b011, 1'b1, 64'd5, 64'd5); step();
    check("subs_eq_res",   result,        64'd0);
    check("subs_eq_zero",  64'(out_zero), 64'd1);
    check("subs_eq_flags", 64'(flags),    64'h6);
    offer(3'b011, 1'b1, 64'd3, 64'd5); step();
    check("subs_neg_res",   result,     64'hFFFF_FFFF_FFFF_FFFE);
    check("subs_neg_flags", 64'(flags), 64'h8);

    // SUBS signed overflow: MIN - 1
    offer(3'b011, 1'b1, 64'h8000_0000_0000_0000, 64'd1); step();
    check("subs_v_res",   result,     64'h7FFF_FFFF_FFFF_FFFF);
    check("subs_v_flags", 64'(flags), 64'h3);

    // Re-establish Z,C then illegal op with set_flags
    offer(3'b011, 1'b1, 64'd5, 64'd5); step();
    check("subs_eq2_flags", 64'(flags), 64'h6);
    offer(3'b111, 1'b1, 64'd9, 64'd4); step();
    check("ill_res",   result,           64'd0);
    check("ill_flag",  64'(out_illegal), 64'd1);
    check("ill_zero",  64'(out_zero),    64'd1);
    check("ill_flags", 64'(flags),       64'h6);
    offer(3'b001, 1'b1, 64'd1, 64'd1); step();
    check("ill001_flag",  64'(out_illegal), 64'd1);
    check("ill001_flags", 64'(flags),       64'h6);

    // CBZ pass-through and logic ops without flag update
    offer(3'b000, 1'b0, 64'd123, 64'd0); step();
    check("pass0_zero",    64'(out_zero),    64'd1);
    check("pass0_illegal", 64'(out_illegal), 64'd0);
    check("pass0_flags",   64'(flags),       64'h6);
    offer(3'b000, 1'b0, 64'd1, 64'hABC); step();
    check("pass_res",  result,        64'hABC);
    check("pass_zero", 64'(out_zero), 64'd0);
    offer(3'b100, 1'b0, 64'hF0F0, 64'hFF00); step();
    check("and_res", result, 64'hF000);
    offer(3'b101, 1'b0, 64'hF0F0, 64'hFF00); step();
    check("or_res", result, 64'hFFF0);
    offer(3'b110, 1'b0, 64'hF0F0, 64'hFF00); step();
    check("xor_res",   result,     64'h0FF0);
    check("xor_flags", 64'(flags), 64'h6);

    // Drain, then backpressure
    in_valid = 1'b0; step();
    check("drain_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    offer(3'b010, 1'b0, 64'd2, 64'd3); step();
    offer(3'b010, 1'b0, 64'd10, 64'd20);
    check("bp1_res",   result,         64'd5);
    check("bp1_valid", 64'(out_valid), 64'd1);
    check("bp1_ready", 64'(in_ready),  64'd0);
    step();
    check("bp2_res",   result,        64'd5);
    check("bp2_ready", 64'(in_ready), 64'd0);
    step();
    check("bp3_res", result, 64'd5);
    out_ready = 1'b1; #1;
    check("bp_ready_up", 64'(in_ready), 64'd1);
    step(); in_valid = 1'b0;
    check("bp_b2b_res",   result,         64'd30);
    check("bp_b2b_valid", 64'(out_valid), 64'd1);
    step();
    check("bp_end_valid", 64'(out_valid), 64'd0);

    // Flush of held result with an ADDS offered
    out_ready = 1'b0;
    offer(3'b100, 1'b0, 64'h77, 64'h0F); step();
    check("fl_held_res", result, 64'h07);
    offer(3'b010, 1'b1, 64'd1, 64'd1);
    flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_flags", 64'(flags),     64'h6);
    step();
    check("fl_valid2", 64'(out_valid), 64'd0);
    check("fl_res",    result,         64'h07);

    // Reset mid-operation
    out_ready = 1'b1;
    offer(3'b010, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); step();
    check("pre_rst_flags", 64'(flags), 64'h9);
    reset = 1'b1;
    offer(3'b010, 1'b1, 64'd1, 64'd1); step();
    reset = 1'b0; in_valid = 1'b0; #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_res",   result,         64'd0);
    check("mid_rst_flags", 64'(flags),     64'd0);
    check("mid_rst_ready", 64'(in_ready),  64'd1);
    step();
    check("mid_rst_drop", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
